ifu_fetch: RTL and testbench

// - Instruction fetch stage of rvseed. Sits directly upstream of the decode stage and drives its ifu2idu_* inputs.
// - Holds the PC and issues word fetches to instruction memory with up to DEPTH requests outstanding.
// - Buffers returned words in a DEPTH-entry FIFO. Redirects to a branch/jump target from EXU and squashes stale fetches.

---
 rtl/ifu_fetch_pkg.sv | 32 +++
 rtl/ifu_fetch_if.sv | 31 +++
 rtl/ifu_fifo.sv | 59 +++++
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the rvseed instruction fetch stage.
// CPU_WIDTH defaults to 32 unless the build defines it.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package ifu_fetch_pkg;

  localparam int unsigned XLEN = `CPU_WIDTH;

  localparam logic [`CPU_WIDTH-1:0] PC_RESET_DEF = '0;

  localparam logic [`CPU_WIDTH-1:0] IFU_INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [`CPU_WIDTH-1:0] pc;
    logic [`CPU_WIDTH-1:0] inst;
  } ifu_entry_t;

  function automatic logic [`CPU_WIDTH-1:0] word_align(
    input logic [`CPU_WIDTH-1:0] a
  );
    return {a[`CPU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port plus IDU handshake.
// master = fetch stage, slave = memory/decode environment.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                  imem_req;
  logic [`CPU_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic                  imem_rvalid;
  logic [`CPU_WIDTH-1:0] imem_rdata;

  logic                  ifu2idu_en;
  logic [`CPU_WIDTH-1:0] ifu2idu_pc;
  logic [`CPU_WIDTH-1:0] ifu2idu_inst;
  logic                  idu2ifu_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rvalid, imem_rdata,
    output ifu2idu_en, ifu2idu_pc, ifu2idu_inst,
    input  idu2ifu_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rvalid, imem_rdata,
    input  ifu2idu_en, ifu2idu_pc, ifu2idu_inst,
    output idu2ifu_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO, DEPTH x W, head visible from registers.
// Flush beats push/pop in the same cycle.
module ifu_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int W     = 2 * `CPU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CAP);
  assign empty = (count == '0);

  // Space is reserved before a word is requested, so this never fires.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !flush)
  );

endmodule

// File: rtl/ifu_fetch.sv
// rvseed instruction fetch stage: PC, outstanding fetches, redirect squash.
// Optional IFU_MISALIGN_CHK_EN flags misaligned redirect targets.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [`CPU_WIDTH-1:0] PC_RESET = PC_RESET_DEF,
  parameter int                    DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  exu2ifu_redirect,
  input  logic [`CPU_WIDTH-1:0] exu2ifu_target,
  output logic                  ifu_misalign_err,
  ifu_fetch_if.master           bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  ifu_state_e state;
  ifu_state_e state_n;

  logic [`CPU_WIDTH-1:0] fetch_pc;
  logic [`CPU_WIDTH-1:0] tgt;
  logic [`CPU_WIDTH-1:0] tag_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         out_n;
  logic [CW-1:0]         disc_n;
  logic [CW-1:0]         icount;
  logic [CW-1:0]         tcount;
  logic                  hs;
  logic                  rv_keep;
  logic                  rv_drop;
  logic                  pop;
  logic                  iempty;
  logic                  ifull;
  logic                  tfull;
  logic                  tempty;
  logic                  err;
  logic                  err_n;
  logic                  unused_ok;
  ifu_entry_t            head;

  assign hs      = bus.imem_req & bus.imem_ack;
  assign rv_keep = bus.imem_rvalid & (discard == '0);
  assign rv_drop = bus.imem_rvalid & (discard != '0);
  assign pop     = bus.ifu2idu_en & bus.idu2ifu_ready;
  assign tgt     = word_align(exu2ifu_target);

  assign bus.imem_req = (state == S_RUN)
                      & ~exu2ifu_redirect
                      & (({1'b0, outstanding}
                         + {1'b0, icount}) < LIM);
  assign bus.imem_addr    = fetch_pc;
  assign bus.ifu2idu_en   = ~iempty;
  assign bus.ifu2idu_pc   = head.pc;
  assign bus.ifu2idu_inst = head.inst;

  ifu_fifo #(.W(`CPU_WIDTH), .DEPTH(DEPTH)) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hs),
    .wdata (fetch_pc),
    .pop   (rv_keep),
    .flush (exu2ifu_redirect),
    .rdata (tag_pc),
    .full  (tfull),
    .empty (tempty),
    .count (tcount)
  );

  ifu_fifo #(.W(2*`CPU_WIDTH), .DEPTH(DEPTH)) u_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rv_keep),
    .wdata ({tag_pc, bus.imem_rdata}),
    .pop   (pop),
    .flush (exu2ifu_redirect),
    .rdata (head),
    .full  (ifull),
    .empty (iempty),
    .count (icount)
  );

  assign unused_ok = &{1'b0, tfull, tempty, tcount, ifull};

  // A response in the redirect cycle retires before the stale count is taken.
  always_comb begin
    out_n  = outstanding + CW'(hs) - CW'(rv_keep);
    disc_n = discard - CW'(rv_drop);
    if (exu2ifu_redirect) begin
      out_n  = '0;
      disc_n = disc_n + outstanding - CW'(rv_keep);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (enable) state_n = S_RUN;
      S_RUN: begin
        if (exu2ifu_redirect && disc_n != '0)
          state_n = S_FLUSH;
        else if (!enable)
          state_n = S_IDLE;
      end
      S_FLUSH: begin
        if (disc_n == '0)
          state_n = enable ? S_RUN : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (err_n) state_n = S_IDLE;
  end

`ifdef IFU_MISALIGN_CHK_EN
  assign err_n = err
               | (exu2ifu_redirect
                  & (|exu2ifu_target[1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_n;
  end
`else
  assign err_n = 1'b0;
  assign err   = 1'b0;
`endif

  assign ifu_misalign_err = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= PC_RESET;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      outstanding <= out_n;
      discard     <= disc_n;
      if (exu2ifu_redirect)
        fetch_pc <= tgt;
      else if (hs)
        fetch_pc <= fetch_pc + `CPU_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch with a variable-latency memory model.
// Expected IDU words are queued by the stimulus and checked by a monitor.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic        err;

  ifu_fetch_if bus();

  ifu_fetch #(.PC_RESET(32'h0), .DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .exu2ifu_redirect (redirect),
    .exu2ifu_target   (target),
    .ifu_misalign_err (err),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // memory: word = addr ^ A5A5_0013, returned lat cycles after ack
  int          lat = 1;
  int          inflight;
  logic [3:0]  vpipe;
  logic [31:0] apipe [4];
  logic        hs;

  assign hs              = bus.imem_req & bus.imem_ack;
  assign bus.imem_rvalid = vpipe[lat-1];
  assign bus.imem_rdata  = apipe[lat-1] ^ 32'hA5A5_0013;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe    <= '0;
      inflight <= 0;
    end else begin
      vpipe    <= {vpipe[2:0], hs};
      apipe[0] <= bus.imem_addr;
      for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
      inflight <= inflight + int'(hs) - int'(bus.imem_rvalid);
    end
  end

  ifu_entry_t  exp_q[$];
  ifu_entry_t  mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          npop = 0;
  int          nreq;
  int          n0;
  logic [31:0] last_pc = '0;
  logic [31:0] a_dis;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_reset(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{pc: p, inst: p ^ 32'hA5A5_0013});
      p = p + 32'd4;
    end
  endtask

  task automatic set_lat(input int l);
    enable = 1'b0;
    step(1);
    for (int i = 0; i < 20 && inflight != 0; i++) step(1);
    chk("drain_inflight", inflight, 0);
    step(4);
    lat = l;
    enable = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.ifu2idu_en && bus.idu2ifu_ready) begin
      npop++;
      last_pc = bus.ifu2idu_pc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %h, none expected",
                 bus.ifu2idu_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", bus.ifu2idu_pc, mon_e.pc);
        chk("pop_inst", bus.ifu2idu_inst, mon_e.inst);
      end
    end
  end

  initial begin
    bus.imem_ack      = 1'b1;
    bus.idu2ifu_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_en", bus.ifu2idu_en, 0);
    chk("rst_pc", bus.ifu2idu_pc, 32'h0);
    chk("rst_inst", bus.ifu2idu_inst, 32'h0);
    chk("rst_err", err, 0);

    step(2);
    exp_reset(32'h0);
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) step(1);
    chk("first_ack", hs, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    step(1);
    chk("lat_en_early", bus.ifu2idu_en, 0);
    step(1);
    chk("lat_en", bus.ifu2idu_en, 1);
    chk("lat_pc", bus.ifu2idu_pc, 32'h0);
    chk("lat_inst", bus.ifu2idu_inst, 32'hA5A5_0013);
    step(10);

    bus.idu2ifu_ready = 1'b0;
    step(5);
    chk("stall_req", bus.imem_req, 0);
    chk("stall_en", bus.ifu2idu_en, 1);
    bus.idu2ifu_ready = 1'b1;
    step(6);

    for (int i = 0; i < 20 && !hs; i++) step(1);
    chk("dis_ack", hs, 1);
    a_dis  = bus.imem_addr;
    enable = 1'b0;
    step(1);
    nreq = 0;
    repeat (4) begin
      nreq += int'(bus.imem_req);
      step(1);
    end
    chk("dis_noreq", nreq, 0);
    chk("dis_last_pc", last_pc, a_dis);
    chk("dis_empty", bus.ifu2idu_en, 0);
    enable = 1'b1;
    step(6);

    set_lat(3);
    for (int i = 0; i < 30 && !(inflight == 2 && !bus.imem_rvalid); i++)
      step(1);
    chk("rd1_inflight", inflight, 2);
    target   = 32'h100;
    redirect = 1'b1;
    #1;
    chk("rd1_noreq", bus.imem_req, 0);
    step(1);
    redirect = 1'b0;
    exp_reset(32'h100);
    chk("rd1_en", bus.ifu2idu_en, 0);
    chk("rd1_flush_req", bus.imem_req, 0);
    chk("rd1_state", 32'(dut.state), 32'(S_FLUSH));
    for (int i = 0; i < 20 && !bus.ifu2idu_en; i++) step(1);
    chk("rd1_pc", bus.ifu2idu_pc, 32'h100);
    step(8);

    set_lat(2);
    for (int i = 0; i < 30 && !(bus.imem_rvalid && bus.ifu2idu_en); i++)
      step(1);
    chk("rd2_cond", bus.imem_rvalid & bus.ifu2idu_en, 1);
    target   = 32'h200;
    redirect = 1'b1;
    #1;
    chk("rd2_noreq", bus.imem_req, 0);
    step(1);
    redirect = 1'b0;
    exp_reset(32'h200);
    chk("rd2_empty", bus.ifu2idu_en, 0);
    for (int i = 0; i < 20 && !bus.ifu2idu_en; i++) step(1);
    chk("rd2_pc", bus.ifu2idu_pc, 32'h200);
    step(6);

    target   = 32'hFFFF_FFF8;
    redirect = 1'b1;
    step(1);
    redirect = 1'b0;
    exp_reset(32'hFFFF_FFF8);
    for (int i = 0; i < 20 && !bus.ifu2idu_en; i++) step(1);
    chk("wrap_pc", bus.ifu2idu_pc, 32'hFFFF_FFF8);
    n0 = npop;
    step(12);
    chk("wrap_progress", 32'(npop - n0 >= 3), 1);

    target   = 32'h302;
    redirect = 1'b1;
    step(1);
    redirect = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    exp_q.delete();
    chk("mis_err", err, 1);
    nreq = 0;
    repeat (6) begin
      nreq += int'(bus.imem_req);
      step(1);
    end
    chk("mis_noreq", nreq, 0);
    chk("mis_sticky", err, 1);
    chk("mis_en", bus.ifu2idu_en, 0);
    rst_n = 1'b0;
    #1;
    chk("mis_rst_err", err, 0);
`else
    exp_reset(32'h300);
    chk("mis_err", err, 0);
    for (int i = 0; i < 20 && !bus.ifu2idu_en; i++) step(1);
    chk("mis_pc", bus.ifu2idu_pc, 32'h300);
    step(4);
    rst_n = 1'b0;
    #1;
`endif
    chk("rst2_req", bus.imem_req, 0);
    chk("rst2_en", bus.ifu2idu_en, 0);
    chk("rst2_addr", bus.imem_addr, 32'h0);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
